// File: rtl/sys_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : sys_pkg                                                |
// | Purpose : Shared state encoding and syscall code constants for  |
// |           the system-call / halt / statistics controller.       |
// | Ports   : n/a                                                    |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package sys_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } state_e;

  localparam int SYS_HALT = 10;
  localparam int SYS_DISP = 34;
  localparam int SYS_SEL  = 35;
  localparam int SYS_CLR  = 36;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : sat_counter                                            |
// | Purpose : Up-counter that sticks at all-ones; clear wins over   |
// |           increment.                                             |
// | Ports   : clk, rst_n (sync, active-low), clr, inc -> q [W-1:0]   |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule
`default_nettype wire

// File: rtl/sys_ctrl_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : sys_ctrl_unit                                          |
// | Purpose : Syscall decoder, halt/resume/single-step FSM, multi-   |
// |           channel display registers and saturating perf counters|
// | Ports   : in  clk, rst_n, sys_valid, sys_code, sys_arg, retire,  |
// |               branch_taken, resume, step, stat_clr               |
// |           out run, halted, disp_data, disp_sel, disp_upd,        |
// |               sys_err, cyc_cnt, inst_cnt, br_cnt                 |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module sys_ctrl_unit
  import sys_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DISP_CH   = 4,
  parameter int CNT_WIDTH = 32,
  parameter int SEL_W     = (DISP_CH > 1) ? $clog2(DISP_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sys_valid,
  input  logic [WIDTH-1:0]         sys_code,
  input  logic [WIDTH-1:0]         sys_arg,
  input  logic                     retire,
  input  logic                     branch_taken,
  input  logic                     resume,
  input  logic                     step,
  input  logic                     stat_clr,
  output logic                     run,
  output logic                     halted,
  output logic [DISP_CH*WIDTH-1:0] disp_data,
  output logic [SEL_W-1:0]         disp_sel,
  output logic [DISP_CH-1:0]       disp_upd,
  output logic                     sys_err,
  output logic [CNT_WIDTH-1:0]     cyc_cnt,
  output logic [CNT_WIDTH-1:0]     inst_cnt,
  output logic [CNT_WIDTH-1:0]     br_cnt
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   disp_q [DISP_CH];
  logic [WIDTH-1:0]   disp_d [DISP_CH];
  logic [SEL_W-1:0]   disp_sel_q, disp_sel_d;
  logic [DISP_CH-1:0] disp_upd_q, disp_upd_d;
  logic               sys_err_q, sys_err_d;

  logic run_w;
  logic sys_act;
  logic is_halt, is_disp, is_sel, is_clr;
  logic cnt_clr;

  assign run_w   = (state_q != HALTED);
  // Syscalls are only honoured while the core is actually executing.
  assign sys_act = sys_valid & run_w;
  assign is_halt = sys_act && (sys_code == WIDTH'(SYS_HALT));
  assign is_disp = sys_act && (sys_code == WIDTH'(SYS_DISP));
  assign is_sel  = sys_act && (sys_code == WIDTH'(SYS_SEL));
  assign is_clr  = sys_act && (sys_code == WIDTH'(SYS_CLR));
  assign cnt_clr = stat_clr | is_clr;

  // Next-state logic; a halt syscall in STEP lands in HALTED just like
  // the unconditional STEP exit, so it needs no special case.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (is_halt) state_d = HALTED;
      end
      HALTED: begin
        if (resume)    state_d = RUN;
        else if (step) state_d = STEP;
      end
      STEP: begin
        state_d = HALTED;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    disp_d     = disp_q;
    disp_sel_d = disp_sel_q;
    disp_upd_d = '0;
    sys_err_d  = 1'b0;
    if (is_sel) begin
      // With a single channel the select bit has nowhere to point.
      disp_sel_d = (DISP_CH == 1) ? '0 : sys_arg[SEL_W-1:0];
    end
    for (int ch = 0; ch < DISP_CH; ch++) begin
      if (is_disp && (disp_sel_q == SEL_W'(ch))) begin
        disp_d[ch]     = sys_arg;
        disp_upd_d[ch] = 1'b1;
      end
    end
    if (sys_act && !is_halt && !is_disp && !is_sel && !is_clr) begin
      sys_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      disp_sel_q <= '0;
      disp_upd_q <= '0;
      sys_err_q  <= 1'b0;
      for (int ch = 0; ch < DISP_CH; ch++) begin
        disp_q[ch] <= '0;
      end
    end else begin
      state_q    <= state_d;
      disp_sel_q <= disp_sel_d;
      disp_upd_q <= disp_upd_d;
      sys_err_q  <= sys_err_d;
      for (int ch = 0; ch < DISP_CH; ch++) begin
        disp_q[ch] <= disp_d[ch];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DISP_CH; gi++) begin : g_disp_out
      assign disp_data[gi*WIDTH +: WIDTH] = disp_q[gi];
    end
  endgenerate

  assign run      = run_w;
  assign halted   = (state_q == HALTED);
  assign disp_sel = disp_sel_q;
  assign disp_upd = disp_upd_q;
  assign sys_err  = sys_err_q;

  sat_counter #(.W(CNT_WIDTH)) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (run_w),
    .q     (cyc_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_inst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (retire & run_w),
    .q     (inst_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_br_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (retire & branch_taken & run_w),
    .q     (br_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_sys_ctrl_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_sys_ctrl_unit                                       |
// | Purpose : Self-checking bench for sys_ctrl_unit (DISP_CH=4,      |
// |           CNT_WIDTH=4 so saturation is reachable quickly).      |
// | Ports   : none                                                   |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_sys_ctrl_unit;

  localparam int WIDTH = 32;
  localparam int DISP_CH = 4;
  localparam int CNT_WIDTH = 4;
  localparam int SEL_W = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     sys_valid;
  logic [WIDTH-1:0]         sys_code;
  logic [WIDTH-1:0]         sys_arg;
  logic                     retire;
  logic                     branch_taken;
  logic                     resume;
  logic                     step;
  logic                     stat_clr;
  logic                     run;
  logic                     halted;
  logic [DISP_CH*WIDTH-1:0] disp_data;
  logic [SEL_W-1:0]         disp_sel;
  logic [DISP_CH-1:0]       disp_upd;
  logic                     sys_err;
  logic [CNT_WIDTH-1:0]     cyc_cnt;
  logic [CNT_WIDTH-1:0]     inst_cnt;
  logic [CNT_WIDTH-1:0]     br_cnt;

  always #5 clk = ~clk;

  sys_ctrl_unit #(
    .WIDTH     (WIDTH),
    .DISP_CH   (DISP_CH),
    .CNT_WIDTH (CNT_WIDTH),
    .SEL_W     (SEL_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sys_valid    (sys_valid),
    .sys_code     (sys_code),
    .sys_arg      (sys_arg),
    .retire       (retire),
    .branch_taken (branch_taken),
    .resume       (resume),
    .step         (step),
    .stat_clr     (stat_clr),
    .run          (run),
    .halted       (halted),
    .disp_data    (disp_data),
    .disp_sel     (disp_sel),
    .disp_upd     (disp_upd),
    .sys_err      (sys_err),
    .cyc_cnt      (cyc_cnt),
    .inst_cnt     (inst_cnt),
    .br_cnt       (br_cnt)
  );

  typedef struct {
    logic         rst_n;
    logic         valid;
    logic [31:0]  code;
    logic [31:0]  arg;
    logic         ret;
    logic         br;
    logic         res;
    logic         stp;
    logic         clr;
    logic         e_run;
    logic         e_halt;
    logic [1:0]   e_sel;
    logic [3:0]   e_upd;
    logic         e_err;
    logic [3:0]   e_c;
    logic [3:0]   e_i;
    logic [3:0]   e_b;
    logic [127:0] e_disp;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  localparam logic [127:0] D0 = 128'h0;
  localparam logic [127:0] DA = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
  localparam logic [127:0] DB = {32'h0, 32'hDEADBEEF, 32'hA5A50001, 32'h0};

  function automatic vec_t mk(
    input logic r, input logic v, input int code, input logic [31:0] arg,
    input logic ret, input logic br, input logic res, input logic stp, input logic clr,
    input logic e_run, input logic e_halt, input int e_sel, input logic [3:0] e_upd,
    input logic e_err, input int e_c, input int e_i, input int e_b, input logic [127:0] e_disp);
    vec_t t;
    t.rst_n = r; t.valid = v; t.code = 32'(code); t.arg = arg;
    t.ret = ret; t.br = br; t.res = res; t.stp = stp; t.clr = clr;
    t.e_run = e_run; t.e_halt = e_halt; t.e_sel = 2'(e_sel); t.e_upd = e_upd;
    t.e_err = e_err; t.e_c = 4'(e_c); t.e_i = 4'(e_i); t.e_b = 4'(e_b); t.e_disp = e_disp;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rst_n = t.rst_n; sys_valid = t.valid; sys_code = t.code; sys_arg = t.arg;
    retire = t.ret; branch_taken = t.br; resume = t.res; step = t.stp; stat_clr = t.clr;
  endtask

  task automatic check(input string name, input vec_t t);
    logic [148:0] got, exp;
    got = {run, halted, disp_sel, disp_upd, sys_err, cyc_cnt, inst_cnt, br_cnt, disp_data};
    exp = {t.e_run, t.e_halt, t.e_sel, t.e_upd, t.e_err, t.e_c, t.e_i, t.e_b, t.e_disp};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got run=%b halt=%b sel=%0d upd=%b err=%b cyc=%0d inst=%0d br=%0d disp=%h, want run=%b halt=%b sel=%0d upd=%b err=%b cyc=%0d inst=%0d br=%0d disp=%h",
               name, run, halted, disp_sel, disp_upd, sys_err, cyc_cnt, inst_cnt, br_cnt, disp_data,
               t.e_run, t.e_halt, t.e_sel, t.e_upd, t.e_err, t.e_c, t.e_i, t.e_b, t.e_disp);
    end
  endtask

  // Apply one vector for a cycle and compare the post-edge state.
  task automatic apply(input string name, input vec_t t);
    drive(t);
    @(posedge clk);
    #1;
    check(name, t);
  endtask

  initial begin
    vec_t t;
    // Table: inputs held for one cycle, expected outputs after that edge.
    //          rst v  code  arg           ret br res stp clr  run hlt sel upd     err  c  i  b  disp
    tbl.push_back(mk(1, 0,  0, 32'h0,        0, 0, 0, 0, 0,   1, 0, 0, 4'b0000, 0,  1, 0, 0, D0)); // v0 idle
    tbl.push_back(mk(1, 1, 35, 32'd6,        0, 0, 0, 0, 0,   1, 0, 2, 4'b0000, 0,  2, 0, 0, D0)); // v1 sel 6 wraps to 2
    tbl.push_back(mk(1, 1, 34, 32'hDEADBEEF, 0, 0, 0, 0, 0,   1, 0, 2, 4'b0100, 0,  3, 0, 0, DA)); // v2 write ch2
    tbl.push_back(mk(1, 0,  0, 32'h0,        0, 0, 0, 0, 0,   1, 0, 2, 4'b0000, 0,  4, 0, 0, DA)); // v3 upd drops
    tbl.push_back(mk(1, 1,  7, 32'h55,       0, 0, 0, 0, 0,   1, 0, 2, 4'b0000, 1,  5, 0, 0, DA)); // v4 unknown code
    tbl.push_back(mk(1, 0,  0, 32'h0,        0, 0, 0, 0, 0,   1, 0, 2, 4'b0000, 0,  6, 0, 0, DA)); // v5 err drops
    tbl.push_back(mk(1, 1, 36, 32'h0,        1, 0, 0, 0, 0,   1, 0, 2, 4'b0000, 0,  0, 0, 0, DA)); // v6 syscall clear
    tbl.push_back(mk(1, 0,  0, 32'h0,        1, 1, 0, 0, 0,   1, 0, 2, 4'b0000, 0,  1, 1, 1, DA)); // v7
    tbl.push_back(mk(1, 0,  0, 32'h0,        1, 0, 0, 0, 0,   1, 0, 2, 4'b0000, 0,  2, 2, 1, DA)); // v8
    tbl.push_back(mk(1, 0,  0, 32'h0,        1, 1, 0, 0, 0,   1, 0, 2, 4'b0000, 0,  3, 3, 2, DA)); // v9
    tbl.push_back(mk(1, 0,  0, 32'h0,        1, 0, 0, 0, 0,   1, 0, 2, 4'b0000, 0,  4, 4, 2, DA)); // v10
    tbl.push_back(mk(1, 0,  0, 32'h0,        1, 0, 0, 0, 0,   1, 0, 2, 4'b0000, 0,  5, 5, 2, DA)); // v11
    tbl.push_back(mk(1, 0,  0, 32'h0,        0, 1, 0, 0, 0,   1, 0, 2, 4'b0000, 0,  6, 5, 2, DA)); // v12 branch w/o retire
    tbl.push_back(mk(1, 1, 10, 32'h0,        1, 0, 0, 0, 0,   0, 1, 2, 4'b0000, 0,  7, 6, 2, DA)); // v13 halt retires
    tbl.push_back(mk(1, 1, 34, 32'h1234,     1, 1, 0, 0, 0,   0, 1, 2, 4'b0000, 0,  7, 6, 2, DA)); // v14 disp ignored
    tbl.push_back(mk(1, 1,  7, 32'h0,        1, 0, 0, 0, 0,   0, 1, 2, 4'b0000, 0,  7, 6, 2, DA)); // v15 no err halted
    tbl.push_back(mk(1, 0,  0, 32'h0,        0, 0, 0, 1, 0,   1, 0, 2, 4'b0000, 0,  7, 6, 2, DA)); // v16 step
    tbl.push_back(mk(1, 0,  0, 32'h0,        1, 0, 0, 0, 0,   0, 1, 2, 4'b0000, 0,  8, 7, 2, DA)); // v17 back to halt
    tbl.push_back(mk(1, 0,  0, 32'h0,        0, 0, 0, 0, 0,   0, 1, 2, 4'b0000, 0,  8, 7, 2, DA)); // v18 stays halted
    tbl.push_back(mk(1, 0,  0, 32'h0,        0, 0, 1, 1, 0,   1, 0, 2, 4'b0000, 0,  8, 7, 2, DA)); // v19 resume wins
    tbl.push_back(mk(1, 0,  0, 32'h0,        0, 0, 0, 0, 0,   1, 0, 2, 4'b0000, 0,  9, 7, 2, DA)); // v20
    tbl.push_back(mk(1, 0,  0, 32'h0,        0, 0, 0, 1, 0,   1, 0, 2, 4'b0000, 0, 10, 7, 2, DA)); // v21 step in RUN
    tbl.push_back(mk(1, 1, 10, 32'h0,        0, 0, 0, 0, 0,   0, 1, 2, 4'b0000, 0, 11, 7, 2, DA)); // v22 halt
    tbl.push_back(mk(1, 0,  0, 32'h0,        0, 0, 0, 1, 0,   1, 0, 2, 4'b0000, 0, 11, 7, 2, DA)); // v23 step
    tbl.push_back(mk(1, 1, 10, 32'h0,        1, 0, 0, 0, 0,   0, 1, 2, 4'b0000, 0, 12, 8, 2, DA)); // v24 halt in STEP
    tbl.push_back(mk(1, 0,  0, 32'h0,        0, 0, 1, 0, 0,   1, 0, 2, 4'b0000, 0, 12, 8, 2, DA)); // v25 resume
    tbl.push_back(mk(1, 1, 35, 32'd5,        0, 0, 0, 0, 0,   1, 0, 1, 4'b0000, 0, 13, 8, 2, DA)); // v26 sel 5 -> 1
    tbl.push_back(mk(1, 1, 34, 32'hA5A50001, 0, 0, 0, 0, 0,   1, 0, 1, 4'b0010, 0, 14, 8, 2, DB)); // v27 write ch1
    tbl.push_back(mk(1, 0,  0, 32'h0,        0, 0, 0, 0, 0,   1, 0, 1, 4'b0000, 0, 15, 8, 2, DB)); // v28
    tbl.push_back(mk(1, 0,  0, 32'h0,        0, 0, 0, 0, 0,   1, 0, 1, 4'b0000, 0, 15, 8, 2, DB)); // v29 saturated
    tbl.push_back(mk(1, 0,  0, 32'h0,        1, 1, 0, 0, 1,   1, 0, 1, 4'b0000, 0,  0, 0, 0, DB)); // v30 clr beats inc
    tbl.push_back(mk(1, 0,  0, 32'h0,        1, 0, 0, 0, 0,   1, 0, 1, 4'b0000, 0,  1, 1, 0, DB)); // v31
    tbl.push_back(mk(1, 1, 10, 32'h0,        0, 0, 0, 0, 0,   0, 1, 1, 4'b0000, 0,  2, 1, 0, DB)); // v32 halt
    tbl.push_back(mk(0, 1, 34, 32'hFFFF,     1, 1, 1, 0, 0,   1, 0, 0, 4'b0000, 0,  0, 0, 0, D0)); // v33 reset mid-op
    tbl.push_back(mk(1, 0,  0, 32'h0,        0, 0, 0, 0, 0,   1, 0, 0, 4'b0000, 0,  1, 0, 0, D0)); // v34

    // Reset held two cycles with random inputs.
    for (int k = 0; k < 2; k++) begin
      rst_n = 1'b0;
      sys_valid = 1'($urandom); sys_code = $urandom; sys_arg = $urandom;
      retire = 1'($urandom); branch_taken = 1'($urandom); resume = 1'($urandom);
      step = 1'($urandom); stat_clr = 1'($urandom);
      @(posedge clk);
      #1;
    end
    t = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 0, 0, 0, 0, D0);
    check("reset", t);

    foreach (tbl[k]) begin
      apply($sformatf("vec%0d", k), tbl[k]);
    end

    // Saturation: clear, then 20 free-running cycles; cyc_cnt climbs to 15 and holds.
    apply("sat_clr", mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 0, D0));
    for (int k = 1; k <= 20; k++) begin
      apply($sformatf("sat%0d", k),
            mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000, 0, (k > 15) ? 15 : k, 0, 0, D0));
    end
    // stat_clr together with retire from a saturated count.
    apply("clr_ret", mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 0, D0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
